// File: rtl/sr_pkg.sv
// Shared types and sizing helpers for the SR command generator.
package sr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } sr_cmd_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int GAP_CYCLES_DEF      = 2;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Per-channel 2-flop synchroniser, debounce counter and registered rising-edge pulse.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;
    logic          rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            rise_q <= 1'b0;
            // Any sample matching the accepted level restarts the stability count.
            if (sync_q[1] != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_q  <= sync_q[1];
                    cnt_q  <= '0;
                    rise_q <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear requests into mutually exclusive one-cycle s/r pulses
// with a forced lockout gap after each pulse.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GAP_CYCLES      = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic conflict,
    output logic busy
);

    localparam int            GW       = cnt_w(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    logic          rise_s, rise_r;
    sr_cmd_state_t state_q;
    logic [GW-1:0] gap_q;
    logic          pend_s_q, pend_r_q;
    logic          s_q, r_q, conflict_q, busy_q;
    logic          dispatch_d;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
        .clk  (clk),
        .rst  (rst),
        .din  (set_in),
        .rise (rise_s)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk  (clk),
        .rst  (rst),
        .din  (clr_in),
        .rise (rise_r)
    );

    // Pending flags are evaluated in IDLE and on the edge that leaves LOCK.
    assign dispatch_d = (state_q == IDLE) || (gap_q == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            pend_s_q   <= pend_s_q | rise_s;
            pend_r_q   <= pend_r_q | rise_r;
            if (state_q == LOCK) gap_q <= gap_q + 1'b1;
            if (dispatch_d) begin
                state_q <= IDLE;
                gap_q   <= '0;
                busy_q  <= 1'b0;
                // A fresh rise in the consuming cycle survives the clear.
                if (pend_s_q && pend_r_q) begin
                    conflict_q <= 1'b1;
                    pend_s_q   <= rise_s;
                    pend_r_q   <= rise_r;
                end else if (pend_s_q) begin
                    s_q      <= 1'b1;
                    pend_s_q <= rise_s;
                    state_q  <= LOCK;
                    busy_q   <= 1'b1;
                end else if (pend_r_q) begin
                    r_q      <= 1'b1;
                    pend_r_q <= rise_r;
                    state_q  <= LOCK;
                    busy_q   <= 1'b1;
                end
            end
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed checks of sr_cmd_gen latency, debounce, conflict, lockout and reset behaviour.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_set = 1'b0, a_clr = 1'b0, b_set = 1'b0, b_clr = 1'b0;
    logic a_s, a_r, a_c, a_busy, b_s, b_r, b_c, b_busy;

    int n_cmp = 0;
    int n_err = 0;
    int e = 0;
    // index 0:s 1:r 2:conflict 3:busy
    int a_cnt[4], a_first[4], b_cnt[4], b_first[4];
    int a_ovl, b_ovl, a_viol, b_viol, a_last, b_last;

    always #5 clk = ~clk;

    sr_cmd_gen dut_a (
        .clk(clk), .rst(rst), .set_in(a_set), .clr_in(a_clr),
        .s(a_s), .r(a_r), .conflict(a_c), .busy(a_busy)
    );

    sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .set_in(b_set), .clr_in(b_clr),
        .s(b_s), .r(b_r), .conflict(b_c), .busy(b_busy)
    );

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic trk_clear();
        for (int i = 0; i < 4; i++) begin
            a_cnt[i] = 0; a_first[i] = -1;
            b_cnt[i] = 0; b_first[i] = -1;
        end
        a_ovl = 0; b_ovl = 0; a_viol = 0; b_viol = 0;
        a_last = -1000; b_last = -1000;
    endtask

    task automatic step();
        logic [3:0] av, bv;
        @(posedge clk); #1;
        e++;
        av = {a_s, a_r, a_c, a_busy};
        bv = {b_s, b_r, b_c, b_busy};
        for (int i = 0; i < 4; i++) begin
            if (av[3-i]) begin a_cnt[i]++; if (a_first[i] < 0) a_first[i] = e; end
            if (bv[3-i]) begin b_cnt[i]++; if (b_first[i] < 0) b_first[i] = e; end
        end
        if (a_s && a_r) a_ovl++;
        if (b_s && b_r) b_ovl++;
        if (a_s || a_r) begin if (e - a_last < 3) a_viol++; a_last = e; end
        if (b_s || b_r) begin if (e - b_last < 5) b_viol++; b_last = e; end
    endtask

    task automatic run_to(input int n);
        while (e < n) step();
    endtask

    // After this, edge 1 is the first edge sampled with rst low.
    task automatic do_reset(input logic hold_set);
        rst = 1'b1;
        a_set = hold_set; a_clr = 1'b0; b_set = 1'b0; b_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        e = 0;
        trk_clear();
    endtask

    initial begin
        trk_clear();

        // Reset state
        step(); step();
        chk("reset_outputs_a", {a_s, a_r, a_c, a_busy}, 0);
        chk("reset_outputs_b", {b_s, b_r, b_c, b_busy}, 0);

        // Clean pulse: set sampled high from edge 10
        do_reset(1'b0);
        run_to(9); a_set = 1'b1;
        run_to(30);
        chk("clean_s_count", a_cnt[0], 1);
        chk("clean_s_edge", a_first[0], 17);
        chk("clean_r_count", a_cnt[1], 0);
        chk("clean_conflict_count", a_cnt[2], 0);
        chk("clean_busy_cycles", a_cnt[3], 3);
        chk("clean_busy_edge", a_first[3], 17);

        // Bounce rejection: 1,0,1,0 at edges 10..13, then held from edge 20
        do_reset(1'b0);
        run_to(9);  a_clr = 1'b1;
        step();     a_clr = 1'b0;
        step();     a_clr = 1'b1;
        step();     a_clr = 1'b0;
        run_to(19); a_clr = 1'b1;
        run_to(35);
        chk("bounce_r_count", a_cnt[1], 1);
        chk("bounce_r_edge", a_first[1], 27);
        chk("bounce_s_count", a_cnt[0], 0);

        // Simultaneous requests from edge 5
        do_reset(1'b0);
        run_to(4); a_set = 1'b1; a_clr = 1'b1;
        run_to(25);
        chk("conflict_count", a_cnt[2], 1);
        chk("conflict_edge", a_first[2], 12);
        chk("conflict_s_count", a_cnt[0], 0);
        chk("conflict_r_count", a_cnt[1], 0);
        chk("conflict_busy_cycles", a_cnt[3], 0);

        // Lockout queueing on GAP=4: s at 12, clear rise lands at 13 -> r at 17
        do_reset(1'b0);
        run_to(4); b_set = 1'b1;
        run_to(7); b_clr = 1'b1;
        run_to(30);
        chk("lock_s_edge", b_first[0], 12);
        chk("lock_r_edge", b_first[1], 17);
        chk("lock_s_count", b_cnt[0], 1);
        chk("lock_r_count", b_cnt[1], 1);
        chk("lock_overlap", b_ovl, 0);
        chk("lock_busy_cycles", b_cnt[3], 10);

        // Reset while a clear request is pending in LOCK
        do_reset(1'b0);
        run_to(4); a_set = 1'b1;
        run_to(5); a_clr = 1'b1;
        run_to(12);
        chk("midrst_s_before", a_s, 1);
        chk("midrst_busy_before", a_busy, 1);
        rst = 1'b1; a_set = 1'b0; a_clr = 1'b0;
        step();
        chk("midrst_outputs", {a_s, a_r, a_c, a_busy}, 0);
        rst = 1'b0;
        trk_clear();
        run_to(40);
        chk("midrst_r_count", a_cnt[1], 0);
        chk("midrst_s_count", a_cnt[0], 0);
        chk("midrst_busy_cycles", a_cnt[3], 0);

        // Set held high through reset is a fresh edge at edge 1
        do_reset(1'b1);
        run_to(20);
        chk("held_s_edge", a_first[0], 8);
        chk("held_s_count", a_cnt[0], 1);
        chk("held_r_count", a_cnt[1], 0);

        // Random bouncing on both DUTs
        do_reset(1'b0);
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 5) == 0) a_set = ~a_set;
            if ($urandom_range(0, 5) == 0) a_clr = ~a_clr;
            if ($urandom_range(0, 5) == 0) b_set = ~b_set;
            if ($urandom_range(0, 5) == 0) b_clr = ~b_clr;
            step();
        end
        chk("stress_overlap_a", a_ovl, 0);
        chk("stress_overlap_b", b_ovl, 0);
        chk("stress_spacing_a", a_viol, 0);
        chk("stress_spacing_b", b_viol, 0);
        chk("stress_activity_a", (a_cnt[0] + a_cnt[1] > 0) ? 1 : 0, 1);
        chk("stress_activity_b", (b_cnt[0] + b_cnt[1] > 0) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
